tcdm_bank_rr_arbiter: RTL



---
 rtl/tcdm_bank_rr_arbiter_if.sv | 41 ++++
 rtl/tcdm_bank_rr_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/tcdm_bank_rr_arbiter_if.sv
// Request/response bundle between NbMasters TCDM requesters, the per-bank arbiter and its SRAM bank.
// The arbiter connects through the slave modport; the requester/bank side connects through master.
interface tcdm_bank_rr_arbiter_if #(
  parameter int unsigned NbMasters = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned IdWidth   = 1
);
  logic [NbMasters-1:0]                req_i;
  logic [NbMasters-1:0][AddrWidth-1:0] add_i;
  logic [NbMasters-1:0]                wen_i;
  logic [NbMasters-1:0][DataWidth-1:0] data_i;
  logic [NbMasters-1:0][BeWidth-1:0]   be_i;
  logic [NbMasters-1:0][IdWidth-1:0]   id_i;
  logic [NbMasters-1:0]                gnt_o;
  logic [NbMasters-1:0]                r_valid_o;
  logic [DataWidth-1:0]                r_data_o;
  logic [IdWidth-1:0]                  r_id_o;

  logic                                bank_req_o;
  logic [AddrWidth-1:0]                bank_add_o;
  logic                                bank_wen_o;
  logic [DataWidth-1:0]                bank_data_o;
  logic [BeWidth-1:0]                  bank_be_o;
  logic [IdWidth-1:0]                  bank_id_o;
  logic                                bank_gnt_i;
  logic [DataWidth-1:0]                bank_r_data_i;

  modport slave (
    input  req_i, add_i, wen_i, data_i, be_i, id_i, bank_gnt_i, bank_r_data_i,
    output gnt_o, r_valid_o, r_data_o, r_id_o,
           bank_req_o, bank_add_o, bank_wen_o, bank_data_o, bank_be_o, bank_id_o
  );

  modport master (
    output req_i, add_i, wen_i, data_i, be_i, id_i, bank_gnt_i, bank_r_data_i,
    input  gnt_o, r_valid_o, r_data_o, r_id_o,
           bank_req_o, bank_add_o, bank_wen_o, bank_data_o, bank_be_o, bank_id_o
  );
endinterface

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter in front of one TCDM bank: muxes NbMasters requesters onto the bank,
// locks the selection while the bank stalls, and steers the 1-cycle response to its owner.
module tcdm_bank_rr_arbiter #(
  parameter int unsigned NbMasters = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned IdWidth   = 1
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  tcdm_bank_rr_arbiter_if.slave  bus
);
  localparam int unsigned SelWidth = (NbMasters > 1) ? $clog2(NbMasters) : 1;
  localparam logic [SelWidth-1:0] LastIdx = SelWidth'(NbMasters - 1);

  logic [SelWidth-1:0]  prio_q;
  logic [SelWidth-1:0]  locked_sel_q;
  logic [SelWidth-1:0]  resp_owner_q;
  logic                 lock_q;
  logic                 resp_pending_q;
  logic [IdWidth-1:0]   r_id_q;

  logic [SelWidth-1:0]  sel;
  logic                 bank_req;
  logic                 handshake;
  logic [AddrWidth-1:0] sel_add;
  logic                 sel_wen;
  logic [DataWidth-1:0] sel_data;
  logic [BeWidth-1:0]   sel_be;
  logic [IdWidth-1:0]   sel_id;

  assign bank_req  = |bus.req_i;
  assign handshake = bank_req & bus.bank_gnt_i;

  // First requester at or after prio_q (circular); a stalled request keeps the bank.
  always_comb begin
    int unsigned idx;
    logic        found;
    sel   = prio_q;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < NbMasters; i++) begin
      idx = 32'(prio_q) + i;
      if (idx >= NbMasters) begin
        idx = idx - NbMasters;
      end
      if (!found && bus.req_i[SelWidth'(idx)]) begin
        sel   = SelWidth'(idx);
        found = 1'b1;
      end
    end
    if (lock_q) begin
      sel = locked_sel_q;
    end
  end

  always_comb begin
    sel_add  = '0;
    sel_wen  = 1'b0;
    sel_data = '0;
    sel_be   = '0;
    sel_id   = '0;
    if (bank_req) begin
      sel_add  = bus.add_i[sel];
      sel_wen  = bus.wen_i[sel];
      sel_data = bus.data_i[sel];
      sel_be   = bus.be_i[sel];
      sel_id   = bus.id_i[sel];
    end
  end

  assign bus.bank_req_o  = bank_req;
  assign bus.bank_add_o  = sel_add;
  assign bus.bank_wen_o  = sel_wen;
  assign bus.bank_data_o = sel_data;
  assign bus.bank_be_o   = sel_be;
  assign bus.bank_id_o   = sel_id;

  always_comb begin
    bus.gnt_o = '0;
    if (handshake) begin
      bus.gnt_o[sel] = 1'b1;
    end
  end

  // Response is suppressed while reset is low so a handshake just before reset never surfaces.
  always_comb begin
    bus.r_valid_o = '0;
    if (resp_pending_q && rst_ni) begin
      bus.r_valid_o[resp_owner_q] = 1'b1;
    end
  end

  assign bus.r_data_o = bus.bank_r_data_i;
  assign bus.r_id_o   = rst_ni ? r_id_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q         <= '0;
      lock_q         <= 1'b0;
      locked_sel_q   <= '0;
      resp_pending_q <= 1'b0;
      resp_owner_q   <= '0;
      r_id_q         <= '0;
    end else begin
      resp_pending_q <= handshake;
      if (handshake) begin
        lock_q       <= 1'b0;
        prio_q       <= (sel == LastIdx) ? '0 : sel + SelWidth'(1);
        resp_owner_q <= sel;
        r_id_q       <= sel_id;
      end else if (bank_req) begin
        lock_q       <= 1'b1;
        locked_sel_q <= sel;
      end
    end
  end
endmodule
